gfx_cmd_queue: RTL

GFX_CMD_QUEUE -- requirements
Module: gfx_cmd_queue

---
 rtl/gfx_cmd_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/gfx_cmd_queue.sv
// gfx_cmd_queue: CPU-to-graphics-controller command FIFO.
// The CPU pushes 32-bit command words through an MMIO strobe; the controller
// consumes them by advancing its own consumer counter (cmd_lo), which the queue
// samples every cycle. Producer/consumer counters are 8-bit and wrap mod 256,
// the array index is the low bits of each counter.
module gfx_cmd_queue #(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 4
) (
  input  logic        mem_clk,
  input  logic        reset,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_wr_data,
  input  logic        cpu_clr_err,
  output logic [31:0] status,
  output logic        irq_space,
  output logic [31:0] cmd,
  output logic [31:0] cmd_hi,
  input  logic [31:0] cmd_lo
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [7:0]  DEPTH_C     = 8'(DEPTH);
  localparam logic [7:0]  LOW_WATER_C = 8'(LOW_WATER);

  logic [31:0]   mem_r [DEPTH];
  logic [7:0]    wr_cnt_r;
  logic [7:0]    rd_cnt_r;
  logic          overflow_r;
  logic          ack_err_r;

  logic [7:0]    ack_cnt_s;
  logic [7:0]    count_s;
  logic [7:0]    delta_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          drop_s;
  logic          pop_ok_s;
  logic          ack_bad_s;
  logic          unused_cmd_lo_s;

  // Occupancy, pop legality and push decision, all from registered counters.
  always_comb begin
    ack_cnt_s = cmd_lo[7:0];
    count_s   = wr_cnt_r - rd_cnt_r;
    delta_s   = ack_cnt_s - rd_cnt_r;
    empty_s   = (count_s == 8'd0);
    full_s    = (count_s == DEPTH_C);
    push_s    = 1'b0;
    drop_s    = 1'b0;
    pop_ok_s  = 1'b0;
    ack_bad_s = 1'b0;
    if (cpu_wr_en) begin
      push_s = ~full_s;
      drop_s = full_s;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
    if (delta_s == 8'd0) begin
      pop_ok_s  = 1'b0;
      ack_bad_s = 1'b0;
    end else if (delta_s <= count_s) begin
      pop_ok_s  = 1'b1;
      ack_bad_s = 1'b0;
    end else begin
      pop_ok_s  = 1'b0;
      ack_bad_s = 1'b1;
    end
  end

  // Command storage; contents deliberately survive reset, only counters clear.
  always_ff @(posedge mem_clk) begin
    if (!reset && push_s) begin
      mem_r[wr_cnt_r[AW-1:0]] <= cpu_wr_data;
    end
  end

  // Producer/consumer counters and sticky error flags.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      wr_cnt_r   <= cmd_lo[7:0];
      rd_cnt_r   <= cmd_lo[7:0];
      overflow_r <= 1'b0;
      ack_err_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_cnt_r <= wr_cnt_r + 8'd1;
      end
      if (pop_ok_s) begin
        rd_cnt_r <= ack_cnt_s;
      end
      // A fresh error outranks a clear arriving in the same cycle.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (cpu_clr_err) begin
        overflow_r <= 1'b0;
      end
      if (ack_bad_s) begin
        ack_err_r <= 1'b1;
      end else if (cpu_clr_err) begin
        ack_err_r <= 1'b0;
      end
    end
  end

  // Upper consumer-counter bits carry no meaning for the queue.
  assign unused_cmd_lo_s = ^cmd_lo[31:8];

  assign cmd       = mem_r[rd_cnt_r[AW-1:0]];
  assign cmd_hi    = {24'h00_0000, wr_cnt_r};
  assign status    = {16'h0000, ack_err_r, overflow_r, full_s, empty_s, 4'h0, count_s};
  assign irq_space = (count_s <= LOW_WATER_C);

endmodule
